// File: rtl/power_avg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : power_avg_pkg
// Description : Width helpers and the saturate/floor-clamp function shared by
//               the mean-power and peak-power outputs.
// Revision    : 1.0 - initial release
// ============================================================================
package power_avg_pkg;

    // Smallest word ever emitted; keeps the downstream log stage away from log(0).
    localparam int OUT_MIN = 1;

    function automatic int acc_width(input int in_w, input int avg_log2);
        return 2 * in_w + avg_log2;
    endfunction

    // Alignment shift from the Q(2*(in_w-1)) power format to the output format.
    function automatic int out_shift(input int in_w, input int out_frac);
        return 2 * (in_w - 1) - out_frac;
    endfunction

    function automatic logic [63:0] sat_clamp(input logic [63:0] value, input int out_w);
        logic [63:0] max_v;
        max_v = (64'd1 << out_w) - 64'd1;
        if (value > max_v) begin
            return max_v;
        end else if (value == 64'd0) begin
            return 64'(OUT_MIN);
        end else begin
            return value;
        end
    endfunction

endpackage : power_avg_pkg
`default_nettype wire

// File: rtl/cplx_mag_sq.sv
`default_nettype none
// ============================================================================
// Module      : cplx_mag_sq
// Description : Registered I^2 and Q^2 of a signed complex sample, plus valid.
// Revision    : 1.0 - initial release
// ============================================================================
module cplx_mag_sq
    import power_avg_pkg::*;
#(
    parameter int IN_WORD_LEN = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_valid,
    input  logic signed [IN_WORD_LEN-1:0] i_i,
    input  logic signed [IN_WORD_LEN-1:0] i_q,
    output logic                          o_valid,
    output logic [2*IN_WORD_LEN-1:0]      o_i_sq,
    output logic [2*IN_WORD_LEN-1:0]      o_q_sq
);

    localparam int c_PW = 2 * IN_WORD_LEN;

    logic signed [c_PW-1:0] w_i_ext;
    logic signed [c_PW-1:0] w_q_ext;
    logic [c_PW-1:0]        w_i_sq_d, r_i_sq_q;
    logic [c_PW-1:0]        w_q_sq_d, r_q_sq_q;
    logic                   w_valid_d, r_valid_q;

    // A square is never negative and (-2^(W-1))^2 fits in 2W bits, so the low
    // half of the signed product is the exact unsigned result.
    always_comb begin
        w_i_ext   = c_PW'(i_i);
        w_q_ext   = c_PW'(i_q);
        w_i_sq_d  = r_i_sq_q;
        w_q_sq_d  = r_q_sq_q;
        w_valid_d = i_valid;
        if (i_valid) begin
            w_i_sq_d = $unsigned(w_i_ext * w_i_ext);
            w_q_sq_d = $unsigned(w_q_ext * w_q_ext);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_i_sq_q  <= '0;
            r_q_sq_q  <= '0;
            r_valid_q <= 1'b0;
        end else begin
            r_i_sq_q  <= w_i_sq_d;
            r_q_sq_q  <= w_q_sq_d;
            r_valid_q <= w_valid_d;
        end
    end

    assign o_valid = r_valid_q;
    assign o_i_sq  = r_i_sq_q;
    assign o_q_sq  = r_q_sq_q;

endmodule : cplx_mag_sq
`default_nettype wire

// File: rtl/power_avg_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : power_avg_accumulator
// Description : Block-averaged |x|^2 of complex samples, emitted as a
//               saturated, floor-clamped unsigned Q1.OUT_FRAC_LEN word.
//               Define POWER_AVG_PEAK_EN to add the Peak_out port.
// Revision    : 1.0 - initial release
// ============================================================================
module power_avg_accumulator
    import power_avg_pkg::*;
#(
    parameter int IN_WORD_LEN  = 16,
    parameter int AVG_LOG2     = 6,
    parameter int OUT_WORD_LEN = 18,
    parameter int OUT_FRAC_LEN = 17
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          Valid_in,
    input  logic signed [IN_WORD_LEN-1:0] I_in,
    input  logic signed [IN_WORD_LEN-1:0] Q_in,
`ifdef POWER_AVG_PEAK_EN
    output logic [OUT_WORD_LEN-1:0]       Peak_out,
`endif
    output logic                          Valid_out,
    output logic [OUT_WORD_LEN-1:0]       Data_out
);

    localparam int                  c_PW       = 2 * IN_WORD_LEN;
    localparam int                  c_ACC_W    = acc_width(IN_WORD_LEN, AVG_LOG2);
    localparam int                  c_SH       = out_shift(IN_WORD_LEN, OUT_FRAC_LEN);
    localparam logic [AVG_LOG2-1:0] c_CNT_LAST = '1;

    generate
        if (c_SH < 0) begin : g_bad_shift
            $error("power_avg_accumulator: OUT_FRAC_LEN too large for IN_WORD_LEN");
        end
        if (AVG_LOG2 < 1 || AVG_LOG2 > 12) begin : g_bad_avg
            $error("power_avg_accumulator: AVG_LOG2 outside 1..12");
        end
    endgenerate

    // ---------------------------------------------------------------- S1
    logic            w_v1;
    logic [c_PW-1:0] w_i_sq;
    logic [c_PW-1:0] w_q_sq;

    cplx_mag_sq #(
        .IN_WORD_LEN (IN_WORD_LEN)
    ) u_mag_sq (
        .clk     (Clock),
        .rst     (Reset),
        .i_valid (Valid_in),
        .i_i     (I_in),
        .i_q     (Q_in),
        .o_valid (w_v1),
        .o_i_sq  (w_i_sq),
        .o_q_sq  (w_q_sq)
    );

    // ---------------------------------------------------------------- S2
    logic [c_PW-1:0]     w_psum;
    logic [AVG_LOG2-1:0] w_cnt_d, r_cnt_q;
    logic [c_ACC_W-1:0]  w_acc_d, r_acc_q;
    logic                w_done_d, r_done_q;

    // Loading on the first sample of a block avoids a separate clear cycle,
    // so consecutive blocks run without a bubble.
    always_comb begin
        w_psum   = w_i_sq + w_q_sq;
        w_cnt_d  = r_cnt_q;
        w_acc_d  = r_acc_q;
        w_done_d = 1'b0;
        if (w_v1) begin
            w_cnt_d  = r_cnt_q + 1'b1;
            w_done_d = (r_cnt_q == c_CNT_LAST);
            if (r_cnt_q == '0) begin
                w_acc_d = c_ACC_W'(w_psum);
            end else begin
                w_acc_d = r_acc_q + c_ACC_W'(w_psum);
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_cnt_q  <= '0;
            r_acc_q  <= '0;
            r_done_q <= 1'b0;
        end else begin
            r_cnt_q  <= w_cnt_d;
            r_acc_q  <= w_acc_d;
            r_done_q <= w_done_d;
        end
    end

    // ---------------------------------------------------------------- S3
    logic [c_ACC_W-1:0]      w_scaled;
    logic [OUT_WORD_LEN-1:0] w_data_d, r_data_q;
    logic                    w_valid_d, r_valid_q;

    always_comb begin
        w_scaled  = (r_acc_q >> AVG_LOG2) >> c_SH;
        w_data_d  = r_data_q;
        w_valid_d = r_done_q;
        if (r_done_q) begin
            w_data_d = OUT_WORD_LEN'(sat_clamp(64'(w_scaled), OUT_WORD_LEN));
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
        end else begin
            r_data_q  <= w_data_d;
            r_valid_q <= w_valid_d;
        end
    end

    assign Valid_out = r_valid_q;
    assign Data_out  = r_data_q;

`ifdef POWER_AVG_PEAK_EN
    logic [c_PW-1:0]         w_peak_d, r_peak_q;
    logic [c_PW-1:0]         w_peak_scaled;
    logic [OUT_WORD_LEN-1:0] w_peak_out_d, r_peak_out_q;

    // Peak lives in the same pipeline slot as the accumulator, so it is
    // final on the same edge that raises done.
    always_comb begin
        w_peak_d      = r_peak_q;
        w_peak_scaled = r_peak_q >> c_SH;
        w_peak_out_d  = r_peak_out_q;
        if (w_v1 && ((r_cnt_q == '0) || (w_psum > r_peak_q))) begin
            w_peak_d = w_psum;
        end
        if (r_done_q) begin
            w_peak_out_d = OUT_WORD_LEN'(sat_clamp(64'(w_peak_scaled), OUT_WORD_LEN));
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_peak_q     <= '0;
            r_peak_out_q <= '0;
        end else begin
            r_peak_q     <= w_peak_d;
            r_peak_out_q <= w_peak_out_d;
        end
    end

    assign Peak_out = r_peak_out_q;
`endif

endmodule : power_avg_accumulator
`default_nettype wire

// File: tb/tb_power_avg_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_power_avg_accumulator
// Description : Self-checking bench for power_avg_accumulator (block mean power,
//               optional peak when POWER_AVG_PEAK_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_power_avg_accumulator;

    localparam int N       = 64;
    localparam int SH      = 13;
    localparam int OUT_MAX = 262143;

    logic               Clock = 1'b0;
    logic               Reset;
    logic               Valid_in;
    logic signed [15:0] I_in;
    logic signed [15:0] Q_in;
    logic               Valid_out;
    logic [17:0]        Data_out;
`ifdef POWER_AVG_PEAK_EN
    logic [17:0]        Peak_out;
`endif

    power_avg_accumulator dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Valid_in  (Valid_in),
        .I_in      (I_in),
        .Q_in      (Q_in),
`ifdef POWER_AVG_PEAK_EN
        .Peak_out  (Peak_out),
`endif
        .Valid_out (Valid_out),
        .Data_out  (Data_out)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [17:0] data;
        logic [17:0] peak;
        int          edge_no;
    } pulse_t;

    typedef struct {
        int          i;
        int          q;
        int          gap;
        logic [17:0] exp_data;
    } vec_t;

    pulse_t got_q[$];
    pulse_t exp_q[$];
    int     cyc      = 0;
    int     checks   = 0;
    int     errors   = 0;
    int     n_pulses = 0;

    // Reference model state: a block is simply the next N accepted samples.
    int     m_cnt  = 0;
    longint m_sum  = 0;
    longint m_peak = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    always @(negedge Clock) begin
        if (Valid_out) begin
            pulse_t p;
            p.data = Data_out;
`ifdef POWER_AVG_PEAK_EN
            p.peak = Peak_out;
`else
            p.peak = 18'd0;
`endif
            p.edge_no = cyc;
            got_q.push_back(p);
            n_pulses++;
        end
    end

    function automatic logic [17:0] clamp(input longint v);
        if (v > OUT_MAX) return 18'h3FFFF;
        if (v == 0)      return 18'd1;
        return 18'(v);
    endfunction

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge Clock);
            Valid_in = 1'b0;
        end
    endtask

    // Drive one accepted sample, then `gap` idle cycles, and advance the model.
    task automatic send(input int i, input int q, input int gap);
        longint p;
        pulse_t e;
        int     edge_no;
        @(negedge Clock);
        Valid_in = 1'b1;
        I_in     = 16'(i);
        Q_in     = 16'(q);
        edge_no  = cyc + 1;
        p = longint'(i) * i + longint'(q) * q;
        if (m_cnt == 0) begin
            m_sum  = p;
            m_peak = p;
        end else begin
            m_sum  = m_sum + p;
            m_peak = (p > m_peak) ? p : m_peak;
        end
        m_cnt++;
        if (m_cnt == N) begin
            e.data    = clamp((m_sum / N) / (64'd1 << SH));
            e.peak    = clamp(m_peak / (64'd1 << SH));
            e.edge_no = edge_no + 2;
            exp_q.push_back(e);
            m_cnt = 0;
        end
        if (gap > 0) idle(gap);
    endtask

    task automatic do_reset(input logic with_valid);
        @(negedge Clock);
        Reset    = 1'b1;
        Valid_in = with_valid;
        I_in     = 16'sh7FFF;
        Q_in     = 16'sh7FFF;
        @(negedge Clock);
        Reset    = 1'b0;
        Valid_in = 1'b0;
        m_cnt    = 0;
    endtask

    task automatic drain(input string name, output logic [17:0] last_data, output logic [17:0] last_peak);
        int     waited;
        pulse_t g;
        pulse_t e;
        idle(1);
        waited = 0;
        while (got_q.size() < exp_q.size() && waited < 40) begin
            @(posedge Clock);
            waited++;
        end
        repeat (6) @(posedge Clock);
        chk({name, " pulse_count"}, got_q.size(), exp_q.size());
        last_data = 18'd0;
        last_peak = 18'd0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            chk({name, " data"}, g.data, e.data);
            chk({name, " latency_edge"}, g.edge_no, e.edge_no);
`ifdef POWER_AVG_PEAK_EN
            chk({name, " peak"}, g.peak, e.peak);
`endif
            last_data = g.data;
            last_peak = g.peak;
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        vec_t        vecs[6];
        logic [17:0] d;
        logic [17:0] pk;

        vecs[0] = '{i: 16384,  q: 0,      gap: 0, exp_data: 18'h08000};
        vecs[1] = '{i: -32768, q: -32768, gap: 0, exp_data: 18'h3FFFF};
        vecs[2] = '{i: 0,      q: 0,      gap: 0, exp_data: 18'h00001};
        vecs[3] = '{i: 23170,  q: 23170,  gap: 0, exp_data: 18'h1FFFA};
        vecs[4] = '{i: 0,      q: -16384, gap: 1, exp_data: 18'h08000};
        vecs[5] = '{i: 128,    q: 64,     gap: 0, exp_data: 18'h00002};

        Reset    = 1'b1;
        Valid_in = 1'b0;
        I_in     = '0;
        Q_in     = '0;
        repeat (3) @(negedge Clock);
        chk("reset valid_out", Valid_out, 0);
        chk("reset data_out", Data_out, 0);
`ifdef POWER_AVG_PEAK_EN
        chk("reset peak_out", Peak_out, 0);
`endif
        Reset = 1'b0;

        for (int v = 0; v < 6; v++) begin
            for (int k = 0; k < N; k++) send(vecs[v].i, vecs[v].q, vecs[v].gap);
            drain($sformatf("vec%0d", v), d, pk);
            chk($sformatf("vec%0d table", v), d, vecs[v].exp_data);
            if (v == 0) begin
                idle(5);
                chk("data_out hold", Data_out, 18'h08000);
            end
        end

        // Sparse block immediately followed by a dense saturating block.
        for (int k = 0; k < N; k++) send(16384, 0, 2);
        for (int k = 0; k < N; k++) send(-32768, -32768, 0);
        drain("sparse_then_b2b", d, pk);
        chk("sparse_then_b2b last", d, 18'h3FFFF);

        // Partial block discarded by reset; the reset-cycle sample is dropped.
        for (int k = 0; k < 40; k++) send(-32768, -32768, 0);
        do_reset(1'b1);
        for (int k = 0; k < N; k++) send(16384, 0, 0);
        drain("after_reset", d, pk);
        chk("after_reset value", d, 18'h08000);
        chk("total pulses so far", n_pulses, 9);

        // Alternating power: mean is half the peak.
        for (int k = 0; k < N; k++) send((k % 2 == 0) ? 16384 : 0, 0, 0);
        drain("alternate", d, pk);
        chk("alternate mean", d, 18'h04000);
`ifdef POWER_AVG_PEAK_EN
        chk("alternate peak", pk, 18'h08000);
`endif

        // Randomized blocks with occasional gaps and mixed magnitudes.
        for (int b = 0; b < 6; b++) begin
            for (int k = 0; k < N; k++) begin
                int ri;
                int rq;
                int scale;
                scale = int'($urandom_range(0, 3));
                ri = (int'($urandom_range(0, 65535)) - 32768) >>> (scale * 4);
                rq = (int'($urandom_range(0, 65535)) - 32768) >>> (scale * 4);
                send(ri, rq, ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0);
            end
            if (b % 2 == 1) drain($sformatf("random%0d", b), d, pk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_power_avg_accumulator
`default_nettype wire

// File: doc/power_avg_accumulator.md
Name: power_avg_accumulator

Overview:
- Upstream feeder for fixedpoint_log_calc.
- Takes signed complex I/Q samples and computes instantaneous power |x|^2 = I^2 + Q^2.
- Averages the power over non-overlapping blocks of 2^AVG_LOG2 accepted samples.
- Emits one unsigned Q1.17 mean-power word per block, saturated and floor-clamped so the downstream log stage never sees zero or an overflowed value.

Parameters:
IN_WORD_LEN, 16, width of signed I/Q inputs, Q1.(IN_WORD_LEN-1)
AVG_LOG2, 6, log2 of block length N (N=64 by default); legal range 1..12
OUT_WORD_LEN, 18, output width; matches log-stage IN_WORD_LEN
OUT_FRAC_LEN, 17, output fractional bits; matches log-stage IN_FRAC_LEN

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  synchronous, active-high reset
Valid_in  input  1  I_in/Q_in valid this cycle; no backpressure, every valid sample is accepted
I_in  input  IN_WORD_LEN  signed in-phase sample
Q_in  input  IN_WORD_LEN  signed quadrature sample
Valid_out  output  1  one-cycle pulse, Data_out valid
Data_out  output  OUT_WORD_LEN  unsigned mean power, Q1.OUT_FRAC_LEN

Behaviour:
- Reset:
  - Valid_out=0, Data_out=0.
  - Sample counter, accumulator and all pipeline valids are cleared.
  - A partial block in progress is discarded and produces no output.
- Stage S1 (on Valid_in):
  - Register I^2 and Q^2, each 2*IN_WORD_LEN bits, unsigned.
  - Register v1 = Valid_in.
  - -32768^2 = 2^30 is exact; no overflow.
- Stage S2 (on v1):
  - PSUM = I^2+Q^2, 2*IN_WORD_LEN bits unsigned, frac 2*(IN_WORD_LEN-1), max 2^31.
  - Accumulator width ACC_W = 2*IN_WORD_LEN+AVG_LOG2.
  - cnt==0: acc <= PSUM (load, no add). Otherwise acc <= acc+PSUM.
  - cnt increments modulo N.
  - When cnt==N-1: done <= 1 for one cycle and cnt wraps to 0.
  - Back-to-back blocks therefore have no bubble.
- Stage S3 (on done):
  - mean = acc >> AVG_LOG2.
  - SH = 2*(IN_WORD_LEN-1) - OUT_FRAC_LEN = 13 by default; scaled = mean >> SH, truncating.
  - If scaled > 2^OUT_WORD_LEN-1: Data_out = all ones (0x3FFFF).
  - Else if scaled == 0: Data_out = 1 (floor clamp, log-safe).
  - Else: Data_out = scaled.
  - Valid_out=1 for exactly one cycle. Data_out holds its value until the next block.
- Latency:
  - The Nth accepted sample is sampled at edge k; Valid_out is high in the cycle after edge k+2.
  - Valid_in gaps of any length stall the count only; pipeline stages still drain.
- Reset asserted concurrently with Valid_in: reset wins, and the sample is dropped.
- Throughput: one sample per clock sustained; one output per N accepted samples.
- Elaboration check: SH must be >= 0.

Optional Feature:
- Macro: POWER_AVG_PEAK_EN.
- Defined:
  - Adds output port Peak_out [OUT_WORD_LEN-1:0].
  - Peak_out is the maximum PSUM within the block, scaled, saturated and clamped exactly as Data_out.
  - Updated on the same edge as Data_out; reset to 0.
  - Peak tracking restarts (load, not compare) on the cnt==0 sample.
- Undefined: port and peak logic are absent; all other behaviour is identical.

Decomposition:
- Package power_avg_pkg:
  - Function acc_width(in_w, avg_log2).
  - Function out_shift(in_w, out_frac).
  - Function sat_clamp(value, out_w), used by Data_out and Peak_out.
  - Constant OUT_MIN=1.
- One sub-module cplx_mag_sq (stage S1): registered squares plus valid, reusable elsewhere in the chain.

Test Plan:
- Scenario 1: 64 valid samples, I=16384, Q=0 -> single Valid_out pulse, Data_out=0x08000 (0.25); latency 3 edges after 64th sample.
- Scenario 2: 64 samples, I=Q=-32768 -> Data_out=0x3FFFF (saturated, true value 2.0).
- Scenario 3: 64 samples, I=Q=0 -> Data_out=0x00001 (floor clamp).
- Scenario 4: 64 samples, I=Q=23170 -> Data_out=0x1FFFA (131066, truncation check).
- Scenario 5: Scenario 1 stimulus with Valid_in high every 3rd cycle, then immediately a back-to-back block of Scenario 2 -> outputs 0x08000 then 0x3FFFF; exactly two pulses; no extra or missing pulses.
- Scenario 6: 40 samples of Scenario 2, Reset for 1 cycle, then 64 samples of Scenario 1 -> no pulse from the partial block; single pulse with 0x08000. With POWER_AVG_PEAK_EN: alternate I=16384/I=0 -> Data_out=0x04000, Peak_out=0x08000.
